// File: rtl/dcache_pkg.sv
// Shared types and constants for the data-cache responder.
package dcache_pkg;

    localparam int DCACHE_OFFSET_W = 3;
    localparam int DCACHE_WORD_W   = 64;

    localparam logic [DCACHE_WORD_W-1:0] DCACHE_OFFSET_MASK = 64'h7;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MEM_RD,
        MEM_WR,
        RESP
    } dcache_state_e;

    // Backing memory is word addressed, so the byte offset is always cleared.
    function automatic logic [DCACHE_WORD_W-1:0] word_align(input logic [DCACHE_WORD_W-1:0] addr);
        return addr & ~DCACHE_OFFSET_MASK;
    endfunction

endpackage

// File: rtl/dcache_if.sv
// Bundles the memory-stage request port and the backing-memory bus of the data cache.
interface dcache_if;
    import dcache_pkg::*;

    logic                     cache_enable;
    logic                     cache_wr_en;
    logic [DCACHE_WORD_W-1:0] cache_wr_addr;
    logic [DCACHE_WORD_W-1:0] cache_rd_addr;
    logic [DCACHE_WORD_W-1:0] cache_wr_value;
    logic [DCACHE_WORD_W-1:0] cache_data;
    logic                     cache_operation_complete;

    logic                     mem_req;
    logic                     mem_we;
    logic [DCACHE_WORD_W-1:0] mem_addr;
    logic [DCACHE_WORD_W-1:0] mem_wdata;
    logic                     mem_ack;
    logic [DCACHE_WORD_W-1:0] mem_rdata;

    modport slave (
        input  cache_enable, cache_wr_en, cache_wr_addr, cache_rd_addr, cache_wr_value,
        output cache_data, cache_operation_complete,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport master (
        output cache_enable, cache_wr_en, cache_wr_addr, cache_rd_addr, cache_wr_value,
        input  cache_data, cache_operation_complete,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );

endinterface

// File: rtl/dcache_array.sv
// Direct-mapped valid/tag/data storage: asynchronous read port, synchronous write port.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int LINES   = 64,
    parameter int TAG_W   = 55,
    parameter int INDEX_W = $clog2(LINES)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [INDEX_W-1:0]       rd_index,
    output logic                     rd_valid,
    output logic [TAG_W-1:0]         rd_tag,
    output logic [DCACHE_WORD_W-1:0] rd_data,
    input  logic                     wr_en,
    input  logic [INDEX_W-1:0]       wr_index,
    input  logic [TAG_W-1:0]         wr_tag,
    input  logic [DCACHE_WORD_W-1:0] wr_data
);

    logic [LINES-1:0]         valid;
    logic [TAG_W-1:0]         tags  [LINES];
    logic [DCACHE_WORD_W-1:0] words [LINES];

    // Only the valid bits need clearing; stale tags and data are unreachable.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tags[wr_index]  <= wr_tag;
            words[wr_index] <= wr_data;
        end
    end

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tags[rd_index];
    assign rd_data  = words[rd_index];

endmodule

// File: rtl/dcache_ctrl.sv
// Write-through, no-write-allocate data-cache controller; define DCACHE_STATS_EN for hit/miss counters.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int LINES = 64
) (
    input  logic        clk,
    input  logic        rst,
    dcache_if.slave     bus
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int IW = $clog2(LINES);
    localparam int TW = DCACHE_WORD_W - DCACHE_OFFSET_W - IW;

    dcache_state_e            state;
    logic                     req_we;
    logic [DCACHE_WORD_W-1:0] req_addr;
    logic [DCACHE_WORD_W-1:0] req_wdata;
    logic                     store_hit;

    logic [IW-1:0]            index;
    logic [TW-1:0]            tag;
    logic                     rd_valid;
    logic [TW-1:0]            rd_tag;
    logic [DCACHE_WORD_W-1:0] rd_data;
    logic                     hit;
    logic                     wr_en;
    logic [DCACHE_WORD_W-1:0] wr_data;

    assign index = req_addr[DCACHE_OFFSET_W +: IW];
    assign tag   = req_addr[DCACHE_WORD_W-1 -: TW];
    assign hit   = rd_valid && (rd_tag == tag);

    // Fills always allocate; stores only refresh a line they already hit on.
    assign wr_en   = !rst && bus.mem_ack &&
                     ((state == MEM_RD) || ((state == MEM_WR) && store_hit));
    assign wr_data = (state == MEM_RD) ? bus.mem_rdata : req_wdata;

    dcache_array #(
        .LINES   (LINES),
        .TAG_W   (TW),
        .INDEX_W (IW)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .rd_index (index),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_index (index),
        .wr_tag   (tag),
        .wr_data  (wr_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state                        <= IDLE;
            req_we                       <= 1'b0;
            req_addr                     <= '0;
            req_wdata                    <= '0;
            store_hit                    <= 1'b0;
            bus.cache_data               <= '0;
            bus.cache_operation_complete <= 1'b0;
            bus.mem_req                  <= 1'b0;
            bus.mem_we                   <= 1'b0;
            bus.mem_addr                 <= '0;
            bus.mem_wdata                <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cache_enable) begin
                        req_we    <= bus.cache_wr_en;
                        req_addr  <= bus.cache_wr_en ? bus.cache_wr_addr : bus.cache_rd_addr;
                        req_wdata <= bus.cache_wr_value;
                        state     <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    store_hit <= hit;
                    if (req_we) begin
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= 1'b1;
                        bus.mem_addr  <= word_align(req_addr);
                        bus.mem_wdata <= req_wdata;
                        state         <= MEM_WR;
                    end else if (hit) begin
                        bus.cache_data               <= rd_data;
                        bus.cache_operation_complete <= 1'b1;
                        state                        <= RESP;
                    end else begin
                        bus.mem_req  <= 1'b1;
                        bus.mem_we   <= 1'b0;
                        bus.mem_addr <= word_align(req_addr);
                        state        <= MEM_RD;
                    end
                end
                MEM_RD: begin
                    if (bus.mem_ack) begin
                        bus.mem_req                  <= 1'b0;
                        bus.cache_data               <= bus.mem_rdata;
                        bus.cache_operation_complete <= 1'b1;
                        state                        <= RESP;
                    end
                end
                MEM_WR: begin
                    if (bus.mem_ack) begin
                        bus.mem_req                  <= 1'b0;
                        bus.mem_we                   <= 1'b0;
                        bus.cache_operation_complete <= 1'b1;
                        state                        <= RESP;
                    end
                end
                RESP: begin
                    if (!bus.cache_enable) begin
                        bus.cache_operation_complete <= 1'b0;
                        state                        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    // Only loads are classified; stores always go to memory regardless of hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if ((state == LOOKUP) && !req_we) begin
            if (hit) begin
                hit_count <= hit_count + 32'd1;
            end else begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed self-checking bench for dcache_ctrl with a cycle-accurate memory responder.
module tb_dcache_ctrl;

    logic clk;
    logic rst;

    dcache_if bus ();

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    dcache_ctrl #(
        .LINES (64)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int          r_done;
    int          r_acks;
    int          r_req_cycles;
    logic [63:0] r_data;
    logic        r_we;
    logic [63:0] r_addr;
    logic [63:0] r_wdata;
    logic        r_req_at_done;
    logic        r_after;

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Cycle 0 is the cycle enable is first sampled; each loop pass observes the next cycle.
    // The memory acknowledges during the (k+1)-th cycle in which mem_req is high.
    task automatic apply_stimulus(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                                  input int k, input logic [63:0] rdata);
        r_done       = -1;
        r_acks       = 0;
        r_req_cycles = 0;
        r_data       = '0;
        r_we         = 1'b0;
        r_addr       = '0;
        r_wdata      = '0;
        @(negedge clk);
        bus.cache_enable   = 1'b1;
        bus.cache_wr_en    = we;
        bus.cache_wr_addr  = we ? addr : 64'hFFFF_FFFF_FFFF_FFF0;
        bus.cache_rd_addr  = we ? 64'hFFFF_FFFF_FFFF_FFF0 : addr;
        bus.cache_wr_value = wdata;
        for (int c = 1; c <= 40 && r_done < 0; c++) begin
            @(negedge clk);
            bus.mem_ack        = 1'b0;
            bus.cache_wr_en    = ~we;
            bus.cache_wr_addr  = 64'h0BAD_0000_0000_0008;
            bus.cache_rd_addr  = 64'h0BAD_0000_0000_0010;
            bus.cache_wr_value = ~wdata;
            if (bus.cache_operation_complete) begin
                r_done        = c;
                r_data        = bus.cache_data;
                r_req_at_done = bus.mem_req;
            end else if (bus.mem_req) begin
                r_req_cycles++;
                if (r_req_cycles == k + 1) begin
                    r_acks++;
                    r_we          = bus.mem_we;
                    r_addr        = bus.mem_addr;
                    r_wdata       = bus.mem_wdata;
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = rdata;
                end
            end
        end
        bus.cache_enable = 1'b0;
        bus.mem_ack      = 1'b0;
        @(negedge clk);
        r_after = bus.cache_operation_complete;
    endtask

    initial begin
        rst                = 1'b1;
        bus.cache_enable   = 1'b0;
        bus.cache_wr_en    = 1'b0;
        bus.cache_wr_addr  = '0;
        bus.cache_rd_addr  = '0;
        bus.cache_wr_value = '0;
        bus.mem_ack        = 1'b0;
        bus.mem_rdata      = '0;
        repeat (3) @(negedge clk);
        check_output("reset_complete", bus.cache_operation_complete, 0);
        check_output("reset_mem_req", bus.mem_req, 0);
        check_output("reset_cache_data", bus.cache_data, 0);
        check_output("reset_mem_addr", bus.mem_addr, 0);
        rst = 1'b0;

        $display("[TB] cold load miss");
        apply_stimulus(1'b0, 64'h1000, 64'h0, 3, 64'hDEADBEEF);
        check_output("miss_done_cycle", 64'(r_done), 6);
        check_output("miss_data", r_data, 64'hDEADBEEF);
        check_output("miss_acks", 64'(r_acks), 1);
        check_output("miss_mem_we", r_we, 0);
        check_output("miss_mem_addr", r_addr, 64'h1000);
        check_output("miss_req_dropped", r_req_at_done, 0);
        check_output("miss_complete_falls", r_after, 0);

        $display("[TB] repeat load hit");
        apply_stimulus(1'b0, 64'h1000, 64'h0, 0, 64'h0);
        check_output("hit_done_cycle", 64'(r_done), 2);
        check_output("hit_data", r_data, 64'hDEADBEEF);
        check_output("hit_no_mem_req", 64'(r_req_cycles), 0);

        $display("[TB] store hit then load");
        apply_stimulus(1'b1, 64'h1000, 64'h55, 0, 64'h0);
        check_output("st_hit_done_cycle", 64'(r_done), 3);
        check_output("st_hit_mem_we", r_we, 1);
        check_output("st_hit_mem_addr", r_addr, 64'h1000);
        check_output("st_hit_mem_wdata", r_wdata, 64'h55);
        check_output("st_hit_data_kept", r_data, 64'hDEADBEEF);
        apply_stimulus(1'b0, 64'h1000, 64'h0, 0, 64'h0);
        check_output("ld_after_st_cycle", 64'(r_done), 2);
        check_output("ld_after_st_data", r_data, 64'h55);

        $display("[TB] store miss does not allocate");
        apply_stimulus(1'b1, 64'h2004, 64'h77, 1, 64'h0);
        check_output("st_miss_done_cycle", 64'(r_done), 4);
        check_output("st_miss_mem_addr", r_addr, 64'h2000);
        check_output("st_miss_mem_wdata", r_wdata, 64'h77);
        apply_stimulus(1'b0, 64'h1000, 64'h0, 0, 64'h0);
        check_output("st_miss_keeps_line_cycle", 64'(r_done), 2);
        check_output("st_miss_keeps_line_data", r_data, 64'h55);
        apply_stimulus(1'b0, 64'h2000, 64'h0, 0, 64'h1234);
        check_output("ld_after_st_miss_acks", 64'(r_acks), 1);
        check_output("ld_after_st_miss_data", r_data, 64'h1234);
        check_output("ld_after_st_miss_cycle", 64'(r_done), 3);

        $display("[TB] same index, different tag");
        apply_stimulus(1'b0, 64'h1000, 64'h0, 0, 64'h55);
        check_output("conflict_a_acks", 64'(r_acks), 1);
        apply_stimulus(1'b0, 64'h1200, 64'h0, 2, 64'hAAAA);
        check_output("conflict_b_acks", 64'(r_acks), 1);
        check_output("conflict_b_addr", r_addr, 64'h1200);
        check_output("conflict_b_cycle", 64'(r_done), 5);
        check_output("conflict_b_data", r_data, 64'hAAAA);
        apply_stimulus(1'b0, 64'h1000, 64'h0, 0, 64'h55);
        check_output("conflict_reload_acks", 64'(r_acks), 1);
        check_output("conflict_reload_data", r_data, 64'h55);

        $display("[TB] reset during memory read");
        @(negedge clk);
        bus.cache_enable  = 1'b1;
        bus.cache_wr_en   = 1'b0;
        bus.cache_rd_addr = 64'h3000;
        repeat (3) @(negedge clk);
        check_output("abort_req_high", bus.mem_req, 1);
        rst              = 1'b1;
        bus.cache_enable = 1'b0;
        @(negedge clk);
        check_output("abort_req_dropped", bus.mem_req, 0);
        check_output("abort_complete_low", bus.cache_operation_complete, 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_output("abort_idle_complete", bus.cache_operation_complete, 0);
            check_output("abort_idle_req", bus.mem_req, 0);
        end
        apply_stimulus(1'b0, 64'h3000, 64'h0, 0, 64'h3333);
        check_output("abort_retry_acks", 64'(r_acks), 1);
        check_output("abort_retry_cycle", 64'(r_done), 3);
        check_output("abort_retry_data", r_data, 64'h3333);
        apply_stimulus(1'b0, 64'h1000, 64'h0, 0, 64'h55);
        check_output("reset_cleared_valid", 64'(r_acks), 1);

`ifdef DCACHE_STATS_EN
        check_output("stats_hits", 64'(hit_count), 0);
        check_output("stats_misses", 64'(miss_count), 2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
